prewish_button_poller: RTL and testbench

Initiator (mentor) end of the prewish single-strobe status handshake. It periodically requests the button-status byte from the debounce responder, or on demand. It latches the returned byte and produces one-cycle press/release event masks for downstream logic such as the blinky mask loader. A timeout recovers the block if the responder never answers.

---
 rtl/prewish_button_poller.sv | 178 +++++++++++++++++
 tb/tb_prewish_button_poller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prewish_button_poller.sv
// Initiator side of the prewish single-strobe status handshake.
// Polls the debounce responder for its button byte, either periodically
// (i_enable) or on demand (i_poll_now). Latches the returned byte, emits
// one-cycle press/release masks, and recovers on a missing response.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | counting toward the next automatic poll, or waiting for poll_now
// STROBE   | STB_O held high for STB_LEN cycles
// WAIT     | STB_O low, waiting up to TIMEOUT cycles for STB_I
module prewish_button_poller #(
  parameter int unsigned POLL_DIV = 1000,
  parameter int unsigned STB_LEN  = 2,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  input  logic       i_enable,
  input  logic       i_poll_now,
  output logic [7:0] o_buttons,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic       o_valid,
  output logic       o_timeout,
  output logic [7:0] o_err_count,
  output logic       o_busy,
  output logic       o_alive
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [15:0] POLL_TC = POLL_DIV[15:0] - 16'd1;
  localparam logic [3:0]  STB_TC  = STB_LEN[3:0] - 4'd1;
  localparam logic [7:0]  TO_TC   = TIMEOUT[7:0] - 8'd1;

  state_t      state_q, state_d;
  logic        stb_q, stb_d;
  logic [15:0] poll_q, poll_d;
  logic [3:0]  strb_q, strb_d;
  logic [7:0]  to_q, to_d;
  logic [7:0]  buttons_q, buttons_d;
  logic [7:0]  pressed_q, pressed_d;
  logic [7:0]  released_q, released_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  err_q, err_d;
  logic        alive_q, alive_d;

  // The request byte is reserved for a future mask; always zero for now.
  assign DAT_O       = 8'h00;
  assign STB_O       = stb_q;
  assign o_buttons   = buttons_q;
  assign o_pressed   = pressed_q;
  assign o_released  = released_q;
  assign o_valid     = valid_q;
  assign o_timeout   = timeout_q;
  assign o_err_count = err_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_alive     = alive_q;

  // Next-state and next-output decode; pulse outputs default low each cycle.
  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    poll_d     = poll_q;
    strb_d     = strb_q;
    to_d       = to_q;
    buttons_d  = buttons_q;
    pressed_d  = 8'h00;
    released_d = 8'h00;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    err_d      = err_q;
    alive_d    = alive_q;

    case (state_q)
      ST_IDLE: begin
        stb_d  = 1'b0;
        strb_d = 4'd0;
        // STB_I pulses here are stray and deliberately ignored.
        if (i_poll_now) begin
          state_d = ST_STROBE;
          stb_d   = 1'b1;
          poll_d  = 16'd0;
        end else if (i_enable) begin
          if (poll_q == POLL_TC) begin
            state_d = ST_STROBE;
            stb_d   = 1'b1;
            poll_d  = 16'd0;
          end else begin
            poll_d = poll_q + 16'd1;
          end
        end else begin
          poll_d = 16'd0;
        end
      end

      ST_STROBE: begin
        // A response during the strobe is a protocol violation; not latched.
        stb_d = 1'b1;
        if (strb_q == STB_TC) begin
          stb_d   = 1'b0;
          to_d    = 8'd0;
          state_d = ST_WAIT;
        end else begin
          strb_d = strb_q + 4'd1;
        end
      end

      ST_WAIT: begin
        stb_d = 1'b0;
        // Response is checked first so it wins over a coincident timeout.
        if (STB_I) begin
          buttons_d  = DAT_I;
          pressed_d  = DAT_I & ~buttons_q;
          released_d = ~DAT_I & buttons_q;
          valid_d    = 1'b1;
          alive_d    = ~alive_q;
          poll_d     = 16'd0;
          state_d    = ST_IDLE;
        end else if (to_q == TO_TC) begin
          timeout_d = 1'b1;
          err_d     = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          poll_d    = 16'd0;
          state_d   = ST_IDLE;
        end else begin
          to_d = to_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
        poll_d  = 16'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q    <= ST_IDLE;
      stb_q      <= 1'b0;
      poll_q     <= 16'd0;
      strb_q     <= 4'd0;
      to_q       <= 8'd0;
      buttons_q  <= 8'h00;
      pressed_q  <= 8'h00;
      released_q <= 8'h00;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= 8'd0;
      alive_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      poll_q     <= poll_d;
      strb_q     <= strb_d;
      to_q       <= to_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      alive_q    <= alive_d;
    end
  end

endmodule

// File: tb/tb_prewish_button_poller.sv
// Bench for prewish_button_poller: directed handshake steps plus randomized
// responder behaviour, checked against a transaction-level model.
module tb_prewish_button_poller;

  localparam int POLL_DIV = 8;
  localparam int STB_LEN  = 2;
  localparam int TIMEOUT  = 16;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b0;
  logic       STB_I = 1'b0;
  logic [7:0] DAT_I = 8'h00;
  logic       i_enable = 1'b0;
  logic       i_poll_now = 1'b0;
  logic       STB_O;
  logic [7:0] DAT_O;
  logic [7:0] o_buttons, o_pressed, o_released, o_err_count;
  logic       o_valid, o_timeout, o_busy, o_alive;

  int total = 0;
  int bad   = 0;

  // Transaction-level model of what the poller should remember.
  logic [7:0] m_buttons;
  int         m_err;
  logic       m_alive;

  always #5 CLK_I = ~CLK_I;

  prewish_button_poller #(
    .POLL_DIV(POLL_DIV),
    .STB_LEN (STB_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .STB_O      (STB_O),
    .DAT_O      (DAT_O),
    .STB_I      (STB_I),
    .DAT_I      (DAT_I),
    .i_enable   (i_enable),
    .i_poll_now (i_poll_now),
    .o_buttons  (o_buttons),
    .o_pressed  (o_pressed),
    .o_released (o_released),
    .o_valid    (o_valid),
    .o_timeout  (o_timeout),
    .o_err_count(o_err_count),
    .o_busy     (o_busy),
    .o_alive    (o_alive)
  );

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_buttons = 8'h00;
    m_err     = 0;
    m_alive   = 1'b1;
  endtask

  task automatic check_reset_values();
    chk("rst_stb_o",    STB_O,       1'b0);
    chk("rst_buttons",  o_buttons,   8'h00);
    chk("rst_pressed",  o_pressed,   8'h00);
    chk("rst_released", o_released,  8'h00);
    chk("rst_valid",    o_valid,     1'b0);
    chk("rst_timeout",  o_timeout,   1'b0);
    chk("rst_err",      o_err_count, 8'h00);
    chk("rst_busy",     o_busy,      1'b0);
    chk("rst_alive",    o_alive,     1'b1);
  endtask

  // From an IDLE cycle with a cleared poll counter, the next strobe must
  // appear exactly exp_gap cycles later; pulses from the last transaction
  // must already be gone, and a stray STB_I in IDLE must not latch.
  task automatic wait_rise(input string tag, input int exp_gap, input bit stray_idle);
    int n;
    n = 0;
    if (stray_idle) begin
      STB_I = 1'b1;
      DAT_I = 8'($urandom);
    end
    do begin
      tick();
      STB_I = 1'b0;
      n++;
      if (n == 1) begin
        chk("pulse_valid_drop",   o_valid,    1'b0);
        chk("pulse_timeout_drop", o_timeout,  1'b0);
        chk("pulse_pressed_drop", o_pressed,  8'h00);
        chk("pulse_release_drop", o_released, 8'h00);
      end
    end while (STB_O !== 1'b1 && n < 2000);
    chk(tag, n, exp_gap);
  endtask

  task automatic fire_poll_now();
    i_poll_now = 1'b1;
    tick();
    i_poll_now = 1'b0;
    chk("poll_now_rise", STB_O, 1'b1);
  endtask

  // Called in the first cycle STB_O is seen high. Runs one request to its
  // end: a response after `delay` WAIT cycles, or silence until timeout.
  task automatic transaction(input bit respond, input int delay, input logic [7:0] data,
                             input bit stray_strobe, input bit poll_in_wait);
    int hi;
    int n;
    logic [7:0] exp_p, exp_r;
    hi = 1;
    chk("busy_strobe", o_busy, 1'b1);
    chk("dat_o_zero", DAT_O, 8'h00);
    if (stray_strobe) begin
      STB_I = 1'b1;
      DAT_I = ~data;
    end
    while (STB_O === 1'b1 && hi < 100) begin
      tick();
      STB_I = 1'b0;
      if (STB_O === 1'b1) hi++;
    end
    chk("strobe_len", hi, STB_LEN);
    chk("busy_wait", o_busy, 1'b1);
    if (poll_in_wait) i_poll_now = 1'b1;
    if (respond) begin
      for (int k = 0; k < delay; k++) begin
        tick();
        i_poll_now = 1'b0;
      end
      STB_I = 1'b1;
      DAT_I = data;
      tick();
      STB_I = 1'b0;
      DAT_I = 8'($urandom);
      i_poll_now = 1'b0;
      exp_p     = data & ~m_buttons;
      exp_r     = ~data & m_buttons;
      m_buttons = data;
      m_alive   = ~m_alive;
      chk("rsp_buttons",  o_buttons,   m_buttons);
      chk("rsp_pressed",  o_pressed,   exp_p);
      chk("rsp_released", o_released,  exp_r);
      chk("rsp_valid",    o_valid,     1'b1);
      chk("rsp_timeout",  o_timeout,   1'b0);
      chk("rsp_alive",    o_alive,     m_alive);
      chk("rsp_err",      o_err_count, m_err[7:0]);
      chk("rsp_busy",     o_busy,      1'b0);
    end else begin
      n = 0;
      while (o_timeout !== 1'b1 && n < 1000) begin
        tick();
        i_poll_now = 1'b0;
        n++;
      end
      if (m_err < 255) m_err++;
      chk("to_gap",     n,           TIMEOUT);
      chk("to_err",     o_err_count, m_err[7:0]);
      chk("to_buttons", o_buttons,   m_buttons);
      chk("to_valid",   o_valid,     1'b0);
      chk("to_busy",    o_busy,      1'b0);
    end
  endtask

  initial begin
    int cnt;
    bit resp;
    model_reset();

    // Reset state.
    RST_I = 1'b0;
    i_enable = 1'b1;
    tick();
    tick();
    check_reset_values();
    RST_I = 1'b1;

    // Periodic polling with a prompt responder: 01, 03, 02.
    wait_rise("first_rise", POLL_DIV, 1'b0);
    transaction(1'b1, 0, 8'h01, 1'b0, 1'b0);
    wait_rise("period_rise", POLL_DIV, 1'b0);
    transaction(1'b1, 0, 8'h03, 1'b0, 1'b0);
    wait_rise("period_rise", POLL_DIV, 1'b0);
    transaction(1'b1, 0, 8'h02, 1'b0, 1'b0);

    // Silent responder, then a response on the timeout terminal edge.
    wait_rise("period_rise", POLL_DIV, 1'b0);
    transaction(1'b0, 0, 8'h00, 1'b0, 1'b0);
    wait_rise("period_rise", POLL_DIV, 1'b0);
    transaction(1'b1, TIMEOUT - 1, 8'hA5, 1'b0, 1'b0);

    // Randomized responder behaviour with stray strobes.
    for (int i = 0; i < 40; i++) begin
      wait_rise("rand_rise", POLL_DIV, 1'($urandom_range(0, 1)));
      resp = ($urandom_range(0, 3) != 0);
      transaction(resp, int'($urandom_range(0, TIMEOUT - 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'b0);
    end

    // Long run of silent polls drives the error counter into saturation.
    for (int i = 0; i < 300; i++) begin
      wait_rise("silent_rise", POLL_DIV, 1'b0);
      transaction(1'b0, 0, 8'h00, 1'b0, 1'b0);
    end
    chk("err_saturated", o_err_count, 8'hFF);

    // Automatic polling off: only poll_now starts a request, and a
    // poll_now raised during WAIT is dropped.
    i_enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3 * POLL_DIV; i++) begin
      tick();
      if (STB_O === 1'b1) cnt++;
    end
    chk("disabled_no_stb", cnt, 0);
    fire_poll_now();
    transaction(1'b1, 2, 8'($urandom), 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 3 * POLL_DIV + TIMEOUT; i++) begin
      tick();
      if (STB_O === 1'b1) cnt++;
    end
    chk("dropped_poll_now", cnt, 0);

    // Reset during STROBE, followed by a late response that must not latch.
    fire_poll_now();
    RST_I = 1'b0;
    tick();
    RST_I = 1'b1;
    model_reset();
    check_reset_values();
    STB_I = 1'b1;
    DAT_I = 8'h5A;
    tick();
    STB_I = 1'b0;
    chk("late_stb_valid",   o_valid,   1'b0);
    chk("late_stb_buttons", o_buttons, 8'h00);

    // Make the outputs non-trivial, then reset during WAIT.
    fire_poll_now();
    transaction(1'b1, 1, 8'h7E, 1'b0, 1'b0);
    fire_poll_now();
    cnt = 0;
    while (STB_O === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("wait_entry", cnt, STB_LEN);
    tick();
    RST_I = 1'b0;
    tick();
    RST_I = 1'b1;
    model_reset();
    check_reset_values();
    STB_I = 1'b1;
    DAT_I = 8'hC3;
    tick();
    STB_I = 1'b0;
    chk("late_stb_valid2",   o_valid,   1'b0);
    chk("late_stb_buttons2", o_buttons, 8'h00);

    // First sample after reset compares against zero.
    fire_poll_now();
    transaction(1'b1, 0, 8'h81, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
